// File: rtl/main_buffer_pkg.sv
// main_buffer_pkg: shared state encoding and default sizes for the main-buffer fill controller.
// Contents: fill_state_t (IDLE, REQ, WAIT, FULL, FIN), DEFAULT_DEPTH, DEFAULT_DATA_W.
`timescale 1ns/1ps
package main_buffer_pkg;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_DATA_W = 8;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, FIN} fill_state_t;
endpackage

// File: rtl/main_buffer_fill_ctrl_slot_counter.sv
// fill_slot_counter: main-buffer write slot index (load counter) with clear and increment.
// Ports: clk, rst (async, active-low), clr (to slot 0, wins over inc), inc (advance one slot),
//        idx (current slot), last (idx is the final slot DEPTH-1).
`timescale 1ns/1ps
module fill_slot_counter #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    logic [IDX_W-1:0] r_idx;

    // DEPTH is a power of two, so incrementing past the last slot wraps to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_idx <= '0;
        else if (clr)
            r_idx <= '0;
        else if (inc)
            r_idx <= r_idx + IDX_W'(1);
    end

    assign idx  = r_idx;
    assign last = r_idx == IDX_W'(DEPTH - 1);
endmodule

// File: rtl/main_buffer_fill_ctrl.sv
// main_buffer_fill_ctrl: fetches DEPTH-word blocks from memory into the main buffer, one block per consume.
// Ports: clk, rst (async, active-low); start/base_addr/num_blocks job request;
//        mem_rd_req/mem_addr/mem_rd_valid/mem_rd_data memory read side (one request outstanding);
//        buf_wr_en/buf_wr_idx/buf_wr_data buffer write side; buf_full/consume handshake;
//        busy (job active), done (one-cycle completion pulse).
`timescale 1ns/1ps
module main_buffer_fill_ctrl
    import main_buffer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_blocks,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              buf_wr_en,
    output logic [IDX_W-1:0]  buf_wr_idx,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              buf_full,
    input  logic              consume,
    output logic              busy,
    output logic              done
);
    fill_state_t       r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_nblk, r_blk_cnt;
    logic              w_accept, w_inc, w_consume, w_last;
    logic [IDX_W-1:0]  w_idx;

    // Events only count in the one state where they are legal; everything else is ignored.
    assign w_accept  = r_state == IDLE && start;
    assign w_inc     = r_state == WAIT && mem_rd_valid;
    assign w_consume = r_state == FULL && consume;

    fill_slot_counter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_slot (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .inc  (w_inc),
        .idx  (w_idx),
        .last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_nblk    <= '0;
            r_blk_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= base_addr;
                r_nblk    <= num_blocks;
                r_blk_cnt <= '0;
            end
            // Address keeps running across blocks, so consecutive blocks are contiguous in memory.
            if (w_inc)
                r_addr <= r_addr + ADDR_W'(1);
            if (w_consume)
                r_blk_cnt <= r_blk_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = num_blocks == 8'd0 ? FIN : REQ;
            REQ:     w_next = WAIT;
            WAIT:    if (mem_rd_valid) w_next = w_last ? FULL : REQ;
            FULL:    if (consume) w_next = r_blk_cnt + 8'd1 == r_nblk ? FIN : REQ;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy        = r_state != IDLE;
    assign mem_rd_req  = r_state == REQ;
    assign mem_addr    = mem_rd_req ? r_addr : '0;
    assign buf_wr_en   = w_inc;
    assign buf_wr_idx  = w_idx;
    assign buf_wr_data = w_inc ? mem_rd_data : '0;
    assign buf_full    = r_state == FULL;
    assign done        = r_state == FIN;
endmodule

// File: tb/tb_main_buffer_fill_ctrl.sv
// tb_main_buffer_fill_ctrl: randomized self-checking bench for main_buffer_fill_ctrl against a job-level reference.
`timescale 1ns/1ps
module tb_main_buffer_fill_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;

    logic              clk = 0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        num_blocks;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              buf_wr_en;
    logic [IDX_W-1:0]  buf_wr_idx;
    logic [DATA_W-1:0] buf_wr_data;
    logic              buf_full;
    logic              consume;
    logic              busy;
    logic              done;

    logic              v_resp, v_spur;
    logic [DATA_W-1:0] d_resp;
    logic [DATA_W-1:0] mem_key;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [ADDR_W-1:0] req_q[$];
    int                req_cyc_q[$];
    logic [IDX_W-1:0]  wr_idx_q[$];
    logic [DATA_W-1:0] wr_dat_q[$];
    int                cons_q[$];
    int                lat_q[$];
    int done_cnt, done_cyc, busy_cnt, full_req_cnt, first_full_cyc;
    logic prev_full;

    assign mem_rd_valid = v_resp | v_spur;
    assign mem_rd_data  = v_resp ? d_resp : 8'hEE;

    main_buffer_fill_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .buf_wr_en(buf_wr_en), .buf_wr_idx(buf_wr_idx), .buf_wr_data(buf_wr_data),
        .buf_full(buf_full), .consume(consume), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: answers each request after a queued or random latency with addr ^ mem_key.
    initial begin
        logic [ADDR_W-1:0] a;
        int l;
        v_resp = 0;
        d_resp = 0;
        forever begin
            @(negedge clk);
            if (mem_rd_req) begin
                a = mem_addr;
                l = lat_q.size() > 0 ? lat_q.pop_front() : int'($urandom_range(1, 4));
                repeat (l) @(posedge clk);
                #1;
                if (rst) begin
                    v_resp = 1;
                    d_resp = a ^ mem_key;
                end
                @(posedge clk);
                #1 v_resp = 0;
            end
        end
    end

    // Observer: records every request, write, done and buf_full interval.
    initial begin
        prev_full = 0;
        forever begin
            @(negedge clk);
            if (mem_rd_req) begin
                req_q.push_back(mem_addr);
                req_cyc_q.push_back(cyc);
            end
            if (buf_wr_en) begin
                wr_idx_q.push_back(buf_wr_idx);
                wr_dat_q.push_back(buf_wr_data);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (buf_full && mem_rd_req) full_req_cnt++;
            if (buf_full && !prev_full && first_full_cyc < 0) first_full_cyc = cyc;
            prev_full = buf_full;
        end
    end

    task automatic clear_mon();
        req_q.delete(); req_cyc_q.delete(); wr_idx_q.delete(); wr_dat_q.delete(); cons_q.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; full_req_cnt = 0; first_full_cyc = -1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n, output int e0);
        @(posedge clk);
        #1 start = 1; base_addr = b; num_blocks = n;
        @(posedge clk);
        #1 start = 0; base_addr = $urandom; num_blocks = $urandom;
        e0 = cyc;
    endtask

    task automatic serve_job(input int n);
        bit ok;
        for (int b = 0; b < n; b++) begin
            ok = 0;
            for (int i = 0; i < 300 && !ok; i++) begin
                @(negedge clk);
                ok = buf_full;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL buf_full_timeout block=%0d got=0 exp=1", b);
                return;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1 consume = 1;
            cons_q.push_back(cyc + 1);
            @(posedge clk);
            #1 consume = 0;
        end
        for (int i = 0; i < 50 && done_cnt == 0; i++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL done_timeout got=0 exp=1");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_job(input logic [7:0] base, input int n, input string nm);
        int nw;
        logic [ADDR_W-1:0] ea;
        nw = n * DEPTH;
        checks++;
        if (req_q.size() != nw) begin
            failures++;
            $display("FAIL %s req_count got=%0d exp=%0d", nm, req_q.size(), nw);
        end
        for (int i = 0; i < nw && i < req_q.size(); i++) begin
            ea = base + ADDR_W'(i);
            checks++;
            if (req_q[i] !== ea) begin
                failures++;
                $display("FAIL %s req_addr[%0d] got=%h exp=%h", nm, i, req_q[i], ea);
            end
        end
        checks++;
        if (wr_idx_q.size() != nw) begin
            failures++;
            $display("FAIL %s write_count got=%0d exp=%0d", nm, wr_idx_q.size(), nw);
        end
        for (int i = 0; i < nw && i < wr_idx_q.size(); i++) begin
            ea = base + ADDR_W'(i);
            checks++;
            if (wr_idx_q[i] !== IDX_W'(i % DEPTH) || wr_dat_q[i] !== (ea ^ mem_key)) begin
                failures++;
                $display("FAIL %s write[%0d] got=idx%0d/%h exp=idx%0d/%h", nm, i, wr_idx_q[i], wr_dat_q[i], i % DEPTH, ea ^ mem_key);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL %s done_count got=%0d exp=1", nm, done_cnt);
        end
        checks++;
        if (full_req_cnt !== 0) begin
            failures++;
            $display("FAIL %s req_while_full got=%0d exp=0", nm, full_req_cnt);
        end
        for (int b = 0; b < n - 1; b++) begin
            if (req_cyc_q.size() > (b + 1) * DEPTH && cons_q.size() > b) begin
                checks++;
                if (req_cyc_q[(b + 1) * DEPTH] !== cons_q[b]) begin
                    failures++;
                    $display("FAIL %s next_req_cycle blk=%0d got=%0d exp=%0d", nm, b, req_cyc_q[(b + 1) * DEPTH], cons_q[b]);
                end
            end
        end
        if (n > 0 && cons_q.size() == n) begin
            checks++;
            if (done_cyc !== cons_q[n - 1]) begin
                failures++;
                $display("FAIL %s done_cycle got=%0d exp=%0d", nm, done_cyc, cons_q[n - 1]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_done got=%b exp=0", nm, busy);
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        logic [31:0] got;
        got = {mem_rd_req, mem_addr, buf_wr_en, buf_wr_idx, buf_wr_data, buf_full, busy, done};
        checks++;
        if (got !== 32'd0) begin
            failures++;
            $display("FAIL %s outputs got=%h exp=0", nm, got);
        end
    endtask

    task automatic test_reset();
        rst = 0; start = 0; base_addr = 0; num_blocks = 0; consume = 0; v_spur = 0; mem_key = 8'hA5;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_single_block();
        int e0;
        clear_mon();
        mem_key = 8'hA5;
        lat_q = {1, 1, 1, 1};
        do_start(8'h10, 8'd1, e0);
        serve_job(1);
        checks++;
        if (first_full_cyc - e0 + 1 !== 9) begin
            failures++;
            $display("FAIL single buf_full_cycle got=%0d exp=9", first_full_cyc - e0 + 1);
        end
        checks++;
        if (req_cyc_q.size() > 0 && req_cyc_q[0] - e0 + 1 !== 1) begin
            failures++;
            $display("FAIL single first_req_cycle got=%0d exp=1", req_cyc_q[0] - e0 + 1);
        end
        check_job(8'h10, 1, "single");
    endtask

    task automatic test_two_blocks();
        int e0;
        clear_mon();
        mem_key = 8'h3C;
        lat_q = {1, 3, 2, 5, 1, 3, 2, 5};
        do_start(8'h20, 8'd2, e0);
        serve_job(2);
        check_job(8'h20, 2, "two_blocks");
    endtask

    task automatic test_zero_blocks();
        int e0;
        clear_mon();
        do_start(8'h55, 8'd0, e0);
        serve_job(0);
        checks++;
        if (done_cyc !== e0) begin
            failures++;
            $display("FAIL zero done_cycle got=%0d exp=%0d", done_cyc, e0);
        end
        checks++;
        if (busy_cnt !== 1) begin
            failures++;
            $display("FAIL zero busy_cycles got=%0d exp=1", busy_cnt);
        end
        check_job(8'h55, 0, "zero");
    endtask

    task automatic illegal_stim();
        for (int i = 0; i < 100 && !mem_rd_req; i++) @(negedge clk);
        v_spur = 1;
        @(posedge clk);
        #1 v_spur = 0; start = 1; base_addr = 8'h99; num_blocks = 8'd5; consume = 1;
        @(posedge clk);
        #1 start = 0; consume = 0;
        for (int i = 0; i < 300 && !buf_full; i++) @(negedge clk);
        @(posedge clk);
        #1 v_spur = 1;
        @(posedge clk);
        #1 v_spur = 0;
    endtask

    task automatic test_illegal();
        int e0;
        logic [7:0] b;
        b = $urandom;
        clear_mon();
        mem_key = $urandom;
        lat_q = {4, 1, 2, 3};
        do_start(b, 8'd2, e0);
        fork
            serve_job(2);
            illegal_stim();
        join
        check_job(b, 2, "illegal");
    endtask

    task automatic test_wrap();
        int e0;
        clear_mon();
        mem_key = 8'h5A;
        do_start(8'hFE, 8'd1, e0);
        serve_job(1);
        check_job(8'hFE, 1, "wrap");
    endtask

    task automatic test_reset_mid();
        int e0;
        clear_mon();
        mem_key = $urandom;
        lat_q = {1, 1, 3, 3};
        do_start($urandom, 8'd1, e0);
        for (int i = 0; i < 100 && wr_idx_q.size() < 2; i++) @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        #1 check_outputs_zero("reset_mid_async");
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 0 || wr_idx_q.size() !== 2) begin
            failures++;
            $display("FAIL reset_mid aborted_job got=done%0d/wr%0d exp=done0/wr2", done_cnt, wr_idx_q.size());
        end
        rst = 1;
        clear_mon();
        mem_key = 8'h81;
        do_start(8'h40, 8'd1, e0);
        serve_job(1);
        check_job(8'h40, 1, "after_reset");
    endtask

    task automatic test_random();
        int e0, n;
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            b = $urandom;
            n = $urandom_range(1, 3);
            clear_mon();
            mem_key = $urandom;
            do_start(b, 8'(n), e0);
            serve_job(n);
            check_job(b, n, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_two_blocks();
        test_zero_blocks();
        test_illegal();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/main_buffer_fill_ctrl.md
Name: main_buffer_fill_ctrl

Overview:
Fill controller directly upstream of the main buffer. It fetches DEPTH consecutive words from external memory and writes them into main-buffer slots 0..DEPTH-1. It then holds the buffer full until the downstream consumer acknowledges, and repeats for a programmed number of blocks. It owns the per-slot write index, which plays the load-counter role for the buffer.

Parameters:
DATA_W, 8, width of one buffer word / memory read data
ADDR_W, 8, external memory address width
DEPTH, 4, words per buffer fill (power of two, ≥2)
IDX_W, $clog2(DEPTH), buffer slot index width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
start  in  1  one-cycle pulse; begins a job (accepted only in IDLE)
base_addr  in  ADDR_W  first memory address of job, sampled on accepted start
num_blocks  in  8  number of DEPTH-word fills in job, sampled on accepted start
mem_rd_req  out  1  read request, one-cycle pulse per word
mem_addr  out  ADDR_W  read address, valid while mem_rd_req=1
mem_rd_valid  in  1  read data valid (≥1 cycle after req)
mem_rd_data  in  DATA_W  read data
buf_wr_en  out  1  main-buffer write strobe
buf_wr_idx  out  IDX_W  main-buffer slot written
buf_wr_data  out  DATA_W  word written
buf_full  out  1  all DEPTH slots hold fresh data for current block
consume  in  1  downstream finished with buffer contents
busy  out  1  job in progress
done  out  1  one-cycle pulse, job complete

Behaviour:
- Reset (rst=0, any state, async): state=IDLE; idx=0; blk_cnt=0; addr register=0. All outputs 0. Mid-job reset abandons the job silently with no done pulse.
- States:
  - IDLE: busy=0. On start, latch base_addr and num_blocks, set idx=0.
    - num_blocks=0 → go to FIN.
    - else → go to REQ.
  - REQ: mem_rd_req=1 and mem_addr=addr for exactly one cycle → WAIT.
  - WAIT: hold until mem_rd_valid=1. On that cycle, combinationally: buf_wr_en=1, buf_wr_idx=idx, buf_wr_data=mem_rd_data.
    - addr increments mod 2^ADDR_W.
    - If idx==DEPTH-1: idx←0, go to FULL.
    - else: idx←idx+1, go to REQ.
  - FULL: buf_full=1 (registered, starts the cycle after the last write). On consume: blk_cnt←blk_cnt+1.
    - If blk_cnt+1==num_blocks → FIN.
    - else → REQ. addr continues, so blocks are contiguous.
  - FIN: done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE.
- Ignored events:
  - start outside IDLE.
  - mem_rd_valid outside WAIT (no write, no state change).
  - consume outside FULL.
- Only one request is outstanding at a time. No new req is issued until the current valid is received.
- Latency:
  - start accepted at edge 0 → mem_rd_req high in cycle 1.
  - With 1-cycle memory, each word takes 2 cycles; buf_full rises 2·DEPTH cycles after the first req.
  - consume → next mem_rd_req in the following cycle (or done, if last block).
- Address wrap: 0xFF+1 → 0x00 with no error indication.
- start and consume in the same cycle: only the one legal in the current state acts.

Decomposition:
- Shared package (main_buffer_pkg): state enum fill_state_t {IDLE, REQ, WAIT, FULL, FIN}; constants DEPTH and DATA_W defaults.
- Sub-module fill_slot_counter (IDX_W wide): inputs clk, rst (async, active-low), clr, inc; outputs idx and last (idx==DEPTH-1). The FSM and the block counter stay in the top.

Test Plan:
- Single block, 1-cycle memory: base_addr=0x10, num_blocks=1, mem returns addr^0xA5. Required: reqs at 0x10..0x13; writes idx 0..3 with data 0xB5, 0xB4, 0xB7, 0xB6; buf_full at cycle 9. Then consume → done pulse 1 cycle later; busy=0 after.
- Two blocks with variable memory latency (1, 3, 2, 5 cycles): num_blocks=2, base=0x20. Required: second block reqs 0x24..0x27 only after consume; exactly 8 writes; one done pulse.
- num_blocks=0: start → done pulse next cycle; no mem_rd_req ever; busy high for exactly 1 cycle.
- Illegal events: start during WAIT, spurious mem_rd_valid in REQ/FULL, consume during WAIT. Required: no extra writes, addresses unchanged, job completes normally.
- Address wrap: base=0xFE, num_blocks=1. Required: reqs 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-op: assert rst=0 in WAIT after 2 writes. Required: outputs 0 immediately (async); after release, a new start at base=0x40 writes from idx 0; no done pulse from the aborted job.
